// File: rtl/adc_capture_pkg.sv
// rtl/adc_capture_pkg.sv - shared types and helpers for the triggered ADC capture block
package adc_capture_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} cap_state_t;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/adc_axis_capture_if.sv
// rtl/adc_axis_capture_if.sv - ADC sample stream in and BRAM write port out of the capture block
interface adc_axis_capture_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 13
);

  logic [DATA_WIDTH-1:0]   s_axis_tdata;
  logic                    s_axis_tvalid;
  logic                    s_axis_tready;
  logic                    bram_en;
  logic [DATA_WIDTH/8-1:0] bram_we;
  logic [ADDR_WIDTH-1:0]   bram_addr;
  logic [DATA_WIDTH-1:0]   bram_din;

  // slave: the capture block (sinks the stream, drives the BRAM port)
  modport slave (
    input  s_axis_tdata, s_axis_tvalid,
    output s_axis_tready, bram_en, bram_we, bram_addr, bram_din
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid,
    input  s_axis_tready, bram_en, bram_we, bram_addr, bram_din
  );

endinterface

// File: rtl/adc_axis_capture.sv
// rtl/adc_axis_capture.sv - circular pre-trigger capture of ADC beats into BRAM with post-trigger count
module adc_axis_capture
  import adc_capture_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 13,
  parameter int DECIM_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  adc_axis_capture_if.slave      bus,
  input  logic                   arm,
  input  logic                   abort,
  input  logic                   trig,
  input  logic [ADDR_WIDTH-1:0]  posttrig,
  input  logic [DECIM_WIDTH-1:0] decim,
  output logic                   busy,
  output logic                   done,
  output logic                   wrapped,
  output logic [ADDR_WIDTH-1:0]  trig_addr,
  output logic [ADDR_WIDTH-1:0]  wr_addr
);

  localparam int                    DEPTH  = depth_of(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST   = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE_A  = ADDR_WIDTH'(1);
  localparam logic [DECIM_WIDTH-1:0] ONE_D = DECIM_WIDTH'(1);

  cap_state_t             state;
  logic [ADDR_WIDTH-1:0]  remaining;
  logic [ADDR_WIDTH-1:0]  posttrig_l;
  logic [DECIM_WIDTH-1:0] decim_l;
  logic [DECIM_WIDTH-1:0] dcnt;

  logic beat, active, qual, trig_zero, wr_fire, arm_ok;

  assign bus.s_axis_tready = !rst;
  assign beat      = bus.s_axis_tvalid & bus.s_axis_tready;
  assign active    = (state == ARMED) || (state == POST);
  assign qual      = beat && (dcnt == '0) && active;
  // a zero-length post window finishes on the trigger itself, so its beat is not stored
  assign trig_zero = (state == ARMED) && trig && (posttrig_l == '0);
  assign wr_fire   = qual && !abort && !trig_zero;
  assign arm_ok    = arm && !abort && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      wrapped       <= 1'b0;
      wr_addr       <= '0;
      trig_addr     <= '0;
      remaining     <= '0;
      posttrig_l    <= '0;
      decim_l       <= '0;
      dcnt          <= '0;
      bus.bram_en   <= 1'b0;
      bus.bram_we   <= '0;
      bus.bram_addr <= '0;
      bus.bram_din  <= '0;
    end else begin
      bus.bram_en <= wr_fire;
      bus.bram_we <= {(DATA_WIDTH/8){wr_fire}};
      if (wr_fire) begin
        bus.bram_addr <= wr_addr;
        bus.bram_din  <= bus.s_axis_tdata;
        wr_addr       <= wr_addr + ONE_A;
        if (wr_addr == LAST) wrapped <= 1'b1;
      end

      if (arm_ok)
        dcnt <= '0;
      else if (beat)
        dcnt <= (dcnt == decim_l) ? '0 : dcnt + ONE_D;

      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (arm) begin
              state      <= ARMED;
              busy       <= 1'b1;
              done       <= 1'b0;
              wr_addr    <= '0;
              wrapped    <= 1'b0;
              posttrig_l <= posttrig;
              decim_l    <= decim;
            end
          end
          ARMED: begin
            if (trig) begin
              trig_addr <= wr_addr;
              if ((posttrig_l == '0) || (wr_fire && (posttrig_l == ONE_A))) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state     <= POST;
                remaining <= wr_fire ? posttrig_l - ONE_A : posttrig_l;
              end
            end
          end
          POST: begin
            if (wr_fire) begin
              if (remaining == ONE_A) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                remaining <= remaining - ONE_A;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_axis_capture.sv
// tb/tb_adc_axis_capture.sv - self-checking bench for adc_axis_capture (DEPTH=16)
module tb_adc_axis_capture;

  localparam int DW = 64;
  localparam int AW = 4;
  localparam int DP = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arm = 1'b0, abort = 1'b0, trig = 1'b0;
  logic [AW-1:0] posttrig = '0;
  logic [7:0]    decim = '0;
  logic          busy, done, wrapped;
  logic [AW-1:0] trig_addr, wr_addr;

  adc_axis_capture_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  adc_axis_capture #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DECIM_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .arm(arm), .abort(abort), .trig(trig),
    .posttrig(posttrig), .decim(decim), .busy(busy), .done(done),
    .wrapped(wrapped), .trig_addr(trig_addr), .wr_addr(wr_addr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit started = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // bench-side BRAM fed from the DUT write port
  logic [DW-1:0] bram_mem [DP];
  always @(posedge clk)
    if (bus.bram_en && bus.bram_we == 8'hFF) bram_mem[bus.bram_addr] <= bus.bram_din;

  // behavioural model: mode 0 idle, 1 armed, 2 post, 3 done
  int          m_mode, m_wa, m_ta, m_left, m_post, m_decim, m_bcount, m_prev_wa;
  bit          m_wrapped, m_en, m_q, m_w, m_arm_ok;
  int          m_addr;
  logic [63:0] m_din;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_wa = 0; m_ta = 0; m_left = 0; m_post = 0; m_decim = 0;
      m_bcount = 0; m_wrapped = 0; m_en = 0;
    end else begin
      m_q = bus.s_axis_tvalid && (m_mode == 1 || m_mode == 2) && (m_bcount % (m_decim + 1) == 0);
      m_w = m_q && !abort && !(m_mode == 1 && trig && m_post == 0);
      m_en = m_w;
      m_prev_wa = m_wa;
      if (m_w) begin
        m_addr = m_wa;
        m_din = bus.s_axis_tdata;
        if (m_wa == DP - 1) m_wrapped = 1;
        m_wa = (m_wa + 1) % DP;
      end
      m_arm_ok = arm && !abort && (m_mode == 0 || m_mode == 3);
      if (m_arm_ok) m_bcount = 0;
      else if (bus.s_axis_tvalid) m_bcount++;
      if (abort) m_mode = 0;
      else if (m_arm_ok) begin
        m_mode = 1; m_wa = 0; m_wrapped = 0; m_post = int'(posttrig); m_decim = int'(decim);
      end else if (m_mode == 1 && trig) begin
        m_ta = m_prev_wa;
        m_left = m_post - (m_w ? 1 : 0);
        m_mode = (m_left == 0) ? 3 : 2;
      end else if (m_mode == 2 && m_w) begin
        m_left--;
        if (m_left == 0) m_mode = 3;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("tready", bus.s_axis_tready, !rst);
        chk("bram_en", bus.bram_en, m_en);
        chk("bram_we", bus.bram_we, m_en ? 64'hFF : 64'h0);
        if (m_en) begin
          chk("bram_addr", bus.bram_addr, m_addr);
          chk("bram_din", bus.bram_din, m_din);
        end
        chk("busy", busy, (m_mode == 1 || m_mode == 2));
        chk("done", done, (m_mode == 3));
        chk("wrapped", wrapped, m_wrapped);
        chk("wr_addr", wr_addr, m_wa);
        chk("trig_addr", trig_addr, m_ta);
      end
    end
  end

  task automatic cyc(input logic v, input logic [63:0] d, input logic a, input logic t, input logic ab);
    bus.s_axis_tvalid = v;
    bus.s_axis_tdata  = d;
    arm = a; trig = t; abort = ab;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = '0;
    @(posedge clk);
    started = 1'b1;
    #1;
    chk("rst_tready", bus.s_axis_tready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(0, 0, 0, 0, 0);
    chk("rel_tready", bus.s_axis_tready, 1);
    chk("rel_en", bus.bram_en, 0);
    chk("rel_busy", busy, 0);
    chk("rel_done", done, 0);

    // basic capture, no wrap
    decim = 0; posttrig = 5;
    cyc(0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) cyc(1, 64'h100 + k, 0, 0, 0);
    cyc(1, 64'h103, 0, 1, 0);
    for (int k = 4; k < 8; k++) cyc(1, 64'h100 + k, 0, 0, 0);
    chk("s2_done", done, 1);
    cyc(1, 64'h1FF, 0, 0, 0);
    cyc(1, 64'h1FF, 0, 0, 0);
    chk("s2_trig_addr", trig_addr, 3);
    chk("s2_wr_addr", wr_addr, 8);
    chk("s2_wrapped", wrapped, 0);
    chk("s2_mem3", bram_mem[3], 64'h103);
    chk("s2_mem7", bram_mem[7], 64'h107);

    // wrap-around history
    posttrig = 4;
    cyc(0, 0, 1, 0, 0);
    for (int k = 0; k < 20; k++) cyc(1, 64'h200 + k, 0, 0, 0);
    cyc(1, 64'h214, 0, 1, 0);
    for (int k = 21; k < 24; k++) cyc(1, 64'h200 + k, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("s3_done", done, 1);
    chk("s3_trig_addr", trig_addr, 4);
    chk("s3_wr_addr", wr_addr, 8);
    chk("s3_wrapped", wrapped, 1);
    chk("s3_mem4", bram_mem[4], 64'h214);
    chk("s3_mem7", bram_mem[7], 64'h217);
    chk("s3_oldest", bram_mem[8], 64'h208);

    // decimation by 3
    decim = 2; posttrig = 3;
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 0);
    for (int k = 1; k < 10; k++) cyc(1, 64'(k), 0, 0, 0);
    chk("s4_done", done, 1);
    chk("s4_wr_addr", wr_addr, 3);
    chk("s4_trig_addr", trig_addr, 0);
    chk("s4_mem0", bram_mem[0], 0);
    chk("s4_mem1", bram_mem[1], 3);
    chk("s4_mem2", bram_mem[2], 6);

    // abort in POST, then arm+abort
    decim = 0; posttrig = 4;
    cyc(0, 0, 1, 0, 0);
    cyc(1, 64'h300, 0, 1, 0);
    cyc(1, 64'h301, 0, 0, 0);
    cyc(1, 64'h302, 0, 0, 1);
    chk("s5_busy", busy, 0);
    chk("s5_done", done, 0);
    chk("s5_wr_addr", wr_addr, 2);
    for (int k = 0; k < 3; k++) cyc(1, 64'h3F0 + k, 0, 0, 0);
    chk("s5_no_write", wr_addr, 2);
    cyc(1, 64'h3FA, 1, 0, 1);
    cyc(1, 64'h3FB, 0, 0, 0);
    chk("s5_arm_abort_busy", busy, 0);
    chk("s5_arm_abort_wa", wr_addr, 2);

    // arm+trig together, then zero-length post window
    posttrig = 0;
    cyc(0, 0, 1, 1, 0);
    chk("s6_busy", busy, 1);
    chk("s6_done", done, 0);
    for (int k = 0; k < 3; k++) cyc(1, 64'h400 + k, 0, 0, 0);
    cyc(1, 64'h403, 0, 1, 0);
    chk("s6_done2", done, 1);
    chk("s6_en", bus.bram_en, 0);
    chk("s6_wr_addr", wr_addr, 3);
    chk("s6_trig_addr", trig_addr, 3);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 499) == 0);
      posttrig = AW'($urandom_range(0, DP - 1));
      decim    = 8'($urandom_range(0, 3));
      cyc(($urandom_range(0, 9) < 7), {$urandom, $urandom},
          ($urandom_range(0, 29) == 0), ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 99) == 0));
    end
    rst = 1'b0;
    cyc(0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
